mode4_tree_sequencer: RTL and testbench
=======================================

// Module: mode4_tree_sequencer
// PURPOSE
//  Issue-side controller for the 4-lane FP reduction tree (2 adders -> 1 adder -> accumulator).
//  Reads VEC_LEN 4-element words from a 1-cycle-latency buffer and presents them as inp0..inp3.
//  Generates the aligned stage2/stage1/stage0 run strobes and a one-cycle accumulator clear.
//  Pulses done when the tree's accumulated sum at outp is final.
// PARAMETERS
//  DATAWIDTH  16  width of one FP element (lane)
//  ADDR_W     8   read-address width
//  LEN_W      8   vec_len width; maximum length is 2^LEN_W-1 words
// PORTS
//  clk         in   1             clock, rising edge
//  reset       in   1             asynchronous, active-high
//  start       in   1             request a reduction; accepted only in IDLE
//  vec_len     in   LEN_W         number of 4-lane words; sampled on accept
//  rd_en       out  1             buffer read strobe
//  rd_addr     out  ADDR_W        word address 0..vec_len-1
//  rd_data     in   4*DATAWIDTH   valid the cycle after rd_en; lane0 in LSBs
//  inp0..inp3  out  DATAWIDTH     registered lane data to the tree
//  stage2_run  out  1             tree stage-2 capture enable
//  stage1_run  out  1             tree stage-1 capture enable
//  stage0_run  out  1             tree accumulate enable
//  acc_clr     out  1             one-cycle pulse; ORed into the tree reset by the integrator
//  busy        out  1             high from accept+1 through the done cycle
//  done        out  1             one-cycle pulse; tree outp holds the final sum
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-operation aborts the run; no done.
//  States: IDLE -> ISSUE -> DRAIN -> FIN -> IDLE.
//   IDLE : start=1 with vec_len=L>0 -> ISSUE. With L=0 -> FIN; done follows after one cycle.
//   ISSUE: rd_en=1 for L cycles, rd_addr increments 0..L-1, then -> DRAIN.
//   DRAIN: waits until the last stage0_run has been issued, then -> FIN.
//   FIN  : done=1 for one cycle, then -> IDLE.
//  Timing, with start accepted at the end of cycle 0 and L>0:
//   acc_clr         : cycle 1
//   rd_en           : cycles 1..L
//   inp regs valid  : cycles 3..L+2 (load rd_data the cycle after rd_en)
//   stage2_run      : cycles 3..L+2
//   stage1_run      : cycles 4..L+3
//   stage0_run      : cycles 5..L+4
//   done            : cycle L+5
//  Timing for L=0: acc_clr in cycle 1, done in cycle 2, no rd_en, no run strobes.
//  Run strobes come from a 4-deep shift register of rd_en; the three strobes are never gapped.
//  inp0..3 hold their last value when not loading.
//  start while busy is ignored, including start in the done cycle.
//   A new start may be accepted in the cycle after done.
//  rd_addr is zero-extended from the word counter.
//   vec_len > 2^ADDR_W wraps the address modulo 2^ADDR_W; the caller must not do this.
//  Arithmetic is performed only in the tree; this block never modifies lane data.
// CONFIGURATION
//  MODE4_SEQ_PERF_EN defined:
//   - Adds output cycle_cnt [15:0].
//   - Cleared on accepted start; increments each cycle busy=1; saturates at 16'hFFFF.
//   - Holds its value after done until the next accepted start. Reset value 0.
//  MODE4_SEQ_PERF_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (bench instantiates this block plus the reduction tree, FP16, 1.0=16'h3C00)
//  1. L=1, word0 = four lanes of 16'h3C00
//     -> stage2/1/0_run in cycles 3/4/5, done in cycle 6, tree outp = 16'h4400 (4.0).
//  2. L=3, all lanes 16'h3C00
//     -> rd_addr 0,1,2 in cycles 1-3, done in cycle 8, outp = 16'h4A00 (12.0).
//     Back-to-back start with L=1 (lanes 16'h4000) the cycle after done
//     -> acc_clr clears the tree; outp = 16'h4800 (8.0).
//  3. L=0 -> acc_clr in cycle 1, done in cycle 2, no rd_en or run strobes; outp = 0.
//  4. start pulsed in cycles 2 and 4 of an L=4 run -> ignored; exactly 4 reads; one done in cycle 9.
//  5. reset asserted in cycle 3 of an L=4 run
//     -> all outputs 0 immediately (asynchronous), no done; a following L=1 run completes normally.
//  6. MODE4_SEQ_PERF_EN with L=5 -> cycle_cnt = 10 after done and holds until the next accepted start.

Source files
------------

// File: rtl/mode4_tree_sequencer.sv
// Issue-side sequencer for the 4-lane FP reduction tree: buffer reads, aligned run strobes, acc clear, done.
// Optional cycle_cnt performance counter when MODE4_SEQ_PERF_EN is defined.
module mode4_tree_sequencer #(
  parameter int DATAWIDTH = 16,
  parameter int ADDR_W    = 8,
  parameter int LEN_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       vec_len,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [4*DATAWIDTH-1:0] rd_data,
  output logic [DATAWIDTH-1:0]   inp0,
  output logic [DATAWIDTH-1:0]   inp1,
  output logic [DATAWIDTH-1:0]   inp2,
  output logic [DATAWIDTH-1:0]   inp3,
  output logic                   stage2_run,
  output logic                   stage1_run,
  output logic                   stage0_run,
  output logic                   acc_clr,
  output logic                   busy,
`ifdef MODE4_SEQ_PERF_EN
  output logic [15:0]            cycle_cnt,
`endif
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [3:0]             sr_q;
  logic                   acc_clr_q;
  logic                   done_q;
  logic [DATAWIDTH-1:0]   inp0_q, inp1_q, inp2_q, inp3_q;
  logic                   accept;

  // The done cycle is already back in IDLE, so done_q blocks a same-cycle restart.
  assign accept = (state_q == IDLE) && !done_q && start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          len_d   = vec_len;
          cnt_d   = '0;
          state_d = (vec_len == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == len_q - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      DRAIN: begin
        // Last stage1 strobe now; the final stage0 strobe lands in FIN, done one cycle later.
        if (sr_q[2] && !sr_q[1] && !sr_q[0]) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      sr_q      <= '0;
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      inp0_q    <= '0;
      inp1_q    <= '0;
      inp2_q    <= '0;
      inp3_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sr_q      <= {sr_q[2:0], rd_en};
      acc_clr_q <= accept;
      done_q    <= (state_q == FIN);
      if (sr_q[0]) begin
        inp0_q <= rd_data[0*DATAWIDTH +: DATAWIDTH];
        inp1_q <= rd_data[1*DATAWIDTH +: DATAWIDTH];
        inp2_q <= rd_data[2*DATAWIDTH +: DATAWIDTH];
        inp3_q <= rd_data[3*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

`ifdef MODE4_SEQ_PERF_EN
  logic [15:0] cycle_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= '0;
    end else if (accept) begin
      cycle_cnt_q <= '0;
    end else if (busy && (cycle_cnt_q != 16'hFFFF)) begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

  assign rd_en      = (state_q == ISSUE);
  assign rd_addr    = ADDR_W'(cnt_q);
  assign inp0       = inp0_q;
  assign inp1       = inp1_q;
  assign inp2       = inp2_q;
  assign inp3       = inp3_q;
  assign stage2_run = sr_q[1];
  assign stage1_run = sr_q[2];
  assign stage0_run = sr_q[3];
  assign acc_clr    = acc_clr_q;
  assign busy       = (state_q != IDLE) || done_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mode4_tree_sequencer.sv
// Bench for mode4_tree_sequencer with a 1-cycle buffer and a behavioural FP16 reduction tree.
// Expected events are queued at start time and popped as the DUT produces them.
module tb_mode4_tree_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  vec_len;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic [15:0] inp0, inp1, inp2, inp3;
  logic        stage2_run, stage1_run, stage0_run, acc_clr, busy, done;
`ifdef MODE4_SEQ_PERF_EN
  logic [15:0] cycle_cnt;
`endif

  mode4_tree_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .inp0(inp0), .inp1(inp1), .inp2(inp2), .inp3(inp3),
    .stage2_run(stage2_run), .stage1_run(stage1_run), .stage0_run(stage0_run),
    .acc_clr(acc_clr), .busy(busy),
`ifdef MODE4_SEQ_PERF_EN
    .cycle_cnt(cycle_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // FP16 helpers for normal positive values and zero
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    if (h[14:0] == 15'd0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return m;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    int e;
    int mant;
    logic [4:0] ex;
    logic [9:0] mf;
    if (x == 0.0) return 16'h0000;
    e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0) begin x = x * 2.0; e--; end
    mant = $rtoi((x - 1.0) * 1024.0);
    ex = 5'(e + 15);
    mf = 10'(mant);
    return {1'b0, ex, mf};
  endfunction

  // 1-cycle-latency buffer
  logic [63:0] mem [0:255];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Reduction tree model: 2 adders -> 1 adder -> accumulator
  real s2a, s2b, s1, acc;
  always @(posedge clk or posedge reset) begin
    if (reset || acc_clr) begin
      s2a <= 0.0; s2b <= 0.0; s1 <= 0.0; acc <= 0.0;
    end else begin
      if (stage2_run) begin
        s2a <= h2r(inp0) + h2r(inp1);
        s2b <= h2r(inp2) + h2r(inp3);
      end
      if (stage1_run) s1 <= s2a + s2b;
      if (stage0_run) acc <= acc + s1;
    end
  end

  typedef struct packed {
    int          c;
    logic [63:0] d;
  } ev_t;

  ev_t q_rd[$], q_s2[$], q_s1[$], q_s0[$], q_clr[$], q_done[$];

  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (rd_en) begin
        if (q_rd.size() == 0) check("rd_extra", {cyc, rd_addr}, 0);
        else begin e = q_rd.pop_front(); check("rd_addr", {cyc, 56'd0, rd_addr}, {e.c, e.d}); end
      end
      if (stage2_run) begin
        if (q_s2.size() == 0) check("s2_extra", stage2_run, 0);
        else begin e = q_s2.pop_front(); check("s2_lanes", {cyc, inp3, inp2, inp1, inp0}, {e.c, e.d}); end
      end
      if (stage1_run) begin
        if (q_s1.size() == 0) check("s1_extra", stage1_run, 0);
        else begin e = q_s1.pop_front(); check("s1_cyc", cyc, e.c); end
      end
      if (stage0_run) begin
        if (q_s0.size() == 0) check("s0_extra", stage0_run, 0);
        else begin e = q_s0.pop_front(); check("s0_cyc", cyc, e.c); end
      end
      if (acc_clr) begin
        if (q_clr.size() == 0) check("clr_extra", acc_clr, 0);
        else begin e = q_clr.pop_front(); check("clr_cyc", cyc, e.c); end
      end
      if (done) begin
        if (q_done.size() == 0) check("done_extra", done, 0);
        else begin
          e = q_done.pop_front();
          check("done_outp", {cyc, 48'd0, r2h(acc)}, {e.c, e.d});
          check("busy_done", busy, 1);
        end
      end
    end
  end

  task automatic push_exp(input int c0, input int len, input logic [63:0] word, input logic [15:0] outp);
    q_clr.push_back('{c: c0 + 1, d: 64'd0});
    for (int i = 0; i < len; i++) begin
      q_rd.push_back('{c: c0 + 1 + i, d: 64'(i)});
      q_s2.push_back('{c: c0 + 3 + i, d: word});
      q_s1.push_back('{c: c0 + 4 + i, d: 64'd0});
      q_s0.push_back('{c: c0 + 5 + i, d: 64'd0});
    end
    q_done.push_back('{c: (len == 0) ? c0 + 2 : c0 + len + 5, d: 64'(outp)});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after done.
  task automatic run(input int len, input logic [63:0] word, input logic [15:0] outp,
                     input int sp1, input int sp2);
    int c0;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = word;
    start   = 1'b1;
    vec_len = 8'(len);
    c0 = cyc;
    push_exp(c0, len, word, outp);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_run", busy, 1);
`ifdef MODE4_SEQ_PERF_EN
    check("cnt_clr", cycle_cnt, 0);
`endif
    n = 0;
    while (q_done.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (cyc == c0 + sp1 || cyc == c0 + sp2) begin
        start = 1'b1; vec_len = 8'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", q_done.size(), 0);
    check("busy_idle", busy, 0);
`ifdef MODE4_SEQ_PERF_EN
    check("cnt_final", cycle_cnt, (len == 0) ? 2 : len + 5);
`endif
  endtask

  function automatic logic [127:0] outvec();
    return {rd_en, rd_addr, inp3, inp2, inp1, inp0, stage2_run, stage1_run, stage0_run,
            acc_clr, busy, done};
  endfunction

  localparam logic [63:0] ONES = {4{16'h3C00}};
  localparam logic [63:0] TWOS = {4{16'h4000}};

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; vec_len = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;
    #1;
    check("rst_outs", outvec(), 0);
    idle(3);
    reset = 1'b0;
    idle(2);
    check("idle_outs", outvec(), 0);
`ifdef MODE4_SEQ_PERF_EN
    check("cnt_rst", cycle_cnt, 0);
`endif

    run(1, ONES, 16'h4400, -1, -1);
    idle(3);
    run(3, ONES, 16'h4A00, -1, -1);
    run(1, TWOS, 16'h4800, -1, -1);
    idle(3);
    // start in the done cycle (cycle 2) must be ignored
    run(0, ONES, 16'h0000, 2, -1);
    idle(4);
    run(4, ONES, 16'h4C00, 2, 4);
    idle(3);

    for (int i = 0; i < 256; i++) mem[i] = ONES;
    start = 1'b1; vec_len = 8'd4;
    c0 = cyc;
    push_exp(c0, 4, ONES, 16'h4C00);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("busy_pre_rst", busy, 1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_async", outvec(), 0);
    q_rd.delete(); q_s2.delete(); q_s1.delete(); q_s0.delete(); q_clr.delete(); q_done.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(10);
    check("rst_quiet", outvec(), 0);
    run(1, ONES, 16'h4400, -1, -1);
    idle(2);

`ifdef MODE4_SEQ_PERF_EN
    run(5, ONES, 16'h4D00, -1, -1);
    idle(4);
    check("cnt_hold", cycle_cnt, 10);
    run(1, ONES, 16'h4400, -1, -1);
    idle(2);
`endif

    check("leftover", q_rd.size() + q_s2.size() + q_s1.size() + q_s0.size() +
                      q_clr.size() + q_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
